// File: rtl/inst_fetch_pf.sv
// Instruction prefetcher: issues single-beat AXI4 reads ahead of the consumer and
// queues {pc, word} pairs in a small FIFO, flushing and discarding stale data on redirect.
module inst_fetch_pf #(
  parameter int          C_OFFSET_WIDTH = 28,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      EXEC,
  input  logic                      REDIRECT,
  input  logic [31:0]               REDIRECT_PC,
  output logic                      I_VALID,
  input  logic                      I_READY,
  output logic [31:0]               I_PC,
  output logic [31:0]               I_INST,
  output logic                      MEM_WAIT,
  output logic                      ERR,
  output logic [C_OFFSET_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                M_AXI_ARLEN,
  output logic [2:0]                M_AXI_ARSIZE,
  output logic [1:0]                M_AXI_ARBURST,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [31:0]               M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RLAST,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          CW       = AW + 1;
  localparam logic [CW:0] DEPTH_V  = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] OFF_MASK = (C_OFFSET_WIDTH >= 32) ? 32'hFFFF_FFFF
                                   : ((32'd1 << C_OFFSET_WIDTH) - 32'd1);

  // Advance by one word, wrapping inside the AXI offset window only.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return (pc & ~OFF_MASK) | ((pc + 32'd4) & OFF_MASK);
  endfunction

  logic [31:0]               fpc;
  logic [31:0]               rpc;
  logic                      ar_vld_p0;
  logic                      ar_stale;
  logic [C_OFFSET_WIDTH-1:0] ar_addr_p0;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             out_cnt;
  logic [CW-1:0]             disc;
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      err_q;
  logic [31:0]               pc_mem   [FIFO_DEPTH];
  logic [31:0]               inst_mem [FIFO_DEPTH];

  logic          i_valid;
  logic          ar_hs;
  logic          r_hs;
  logic          r_drop;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW:0]   slots;
  logic          unused_bits;

  assign i_valid = (cnt != '0);
  assign ar_hs   = ar_vld_p0 & M_AXI_ARREADY;
  assign r_hs    = M_AXI_RVALID;
  assign r_drop  = r_hs & (disc != '0);
  assign push    = r_hs & ~r_drop & ~REDIRECT;
  assign pop     = i_valid & I_READY & ~REDIRECT;
  // Every outstanding request already owns a FIFO slot, so a push can never overflow.
  assign slots   = {1'b0, cnt} + {1'b0, out_cnt};
  assign issue   = ~ar_vld_p0 & EXEC & ~REDIRECT & (slots < DEPTH_V);

  // AR request stage
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ar_vld_p0 <= 1'b0;
      ar_stale  <= 1'b0;
      fpc       <= RESET_PC;
    end else begin
      if (issue) ar_vld_p0 <= 1'b1;
      else if (ar_hs) ar_vld_p0 <= 1'b0;

      // A request left pending across a redirect must not advance the new fetch PC.
      if (REDIRECT) ar_stale <= ar_vld_p0 & ~M_AXI_ARREADY;
      else if (ar_hs) ar_stale <= 1'b0;

      if (REDIRECT) fpc <= {REDIRECT_PC[31:2], 2'b00};
      else if (ar_hs && !ar_stale) fpc <= pc_inc(fpc);
    end
  end

  always_ff @(posedge CLK) begin
    if (issue) ar_addr_p0 <= fpc[C_OFFSET_WIDTH-1:0];
  end

  // Response accounting and FIFO control
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      out_cnt <= '0;
      disc    <= '0;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rpc     <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      unique case ({ar_hs, r_hs})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: ;
      endcase

      if (REDIRECT) disc <= out_cnt + CW'(ar_vld_p0) - CW'(r_hs);
      else if (r_drop) disc <= disc - CW'(1);

      if (REDIRECT) begin
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        rpc    <= {REDIRECT_PC[31:2], 2'b00};
      end else begin
        unique case ({push, pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: ;
        endcase
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rpc    <= pc_inc(rpc);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end

      if (r_hs && (M_AXI_RRESP != 2'b00)) err_q <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rpc;
      inst_mem[wr_ptr] <= M_AXI_RDATA;
    end
  end

  assign I_VALID       = i_valid;
  assign I_PC          = pc_mem[rd_ptr];
  assign I_INST        = inst_mem[rd_ptr];
  assign MEM_WAIT      = RSTN & EXEC & ~i_valid;
  assign ERR           = err_q;
  assign M_AXI_ARADDR  = ar_addr_p0;
  assign M_AXI_ARVALID = ar_vld_p0;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_RREADY  = 1'b1;
  assign unused_bits   = ^{M_AXI_RLAST, REDIRECT_PC[1:0]};

endmodule

// File: tb/tb_inst_fetch_pf.sv
// Directed bench for inst_fetch_pf with an in-order single-beat AXI read slave.
module tb_inst_fetch_pf;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        EXEC = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        I_READY = 1'b0;
  logic        I_VALID, MEM_WAIT, ERR;
  logic [31:0] I_PC, I_INST;
  logic [27:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST = 1'b1;

  int unsigned ar_delay = 0;
  logic        r_en = 1'b1;
  int unsigned err_beat = 32'hFFFF_FFFF;
  logic [27:0] rq [16];
  int unsigned rq_wp, rq_rp, ar_wait;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          n_ar  = 0;
  logic [31:0] pop_pc   [256];
  logic [31:0] pop_inst [256];
  logic [27:0] ar_log   [256];
  int          pb, ab;

  inst_fetch_pf #(.C_OFFSET_WIDTH(28), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RSTN(RSTN), .EXEC(EXEC), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .I_VALID(I_VALID), .I_READY(I_READY), .I_PC(I_PC), .I_INST(I_INST),
    .MEM_WAIT(MEM_WAIT), .ERR(ERR),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
    .M_AXI_ARBURST(ARBURST), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [27:0] a);
    case (a)
      28'h0:   return 32'h3E80_0093;
      28'h4:   return 32'h7D00_8113;
      28'h8:   return 32'hC181_0193;
      28'hC:   return 32'h8301_8213;
      28'h10:  return 32'h3E82_0293;
      default: return 32'hA500_0000 ^ {4'h0, a};
    endcase
  endfunction

  // Slave: AR accepted after ar_delay waiting cycles, R returned in order from the next cycle.
  assign ARREADY = ARVALID && (ar_wait >= ar_delay);
  assign RVALID  = r_en && (rq_wp != rq_rp);
  assign RDATA   = mem_word(rq[rq_rp[3:0]]);
  assign RRESP   = (rq_rp == err_beat) ? 2'b10 : 2'b00;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rq_wp   <= 0;
      rq_rp   <= 0;
      ar_wait <= 0;
    end else begin
      if (ARVALID && ARREADY) begin
        rq[rq_wp[3:0]] <= ARADDR;
        rq_wp          <= rq_wp + 1;
        ar_wait        <= 0;
      end else if (ARVALID) begin
        ar_wait <= ar_wait + 1;
      end
      if (RVALID && RREADY) rq_rp <= rq_rp + 1;
    end
  end

  always @(negedge CLK) begin
    if (RSTN && I_VALID && I_READY) begin
      pop_pc[n_pop[7:0]]   <= I_PC;
      pop_inst[n_pop[7:0]] <= I_INST;
      n_pop                <= n_pop + 1;
    end
    if (RSTN && ARVALID && ARREADY) begin
      ar_log[n_ar[7:0]] <= ARADDR;
      n_ar              <= n_ar + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    pb = n_pop;
    ab = n_ar;
  endtask

  task automatic wait_pops(input int target, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (n_pop >= target) break;
      step();
    end
    check(tag, 32'(n_pop >= target), 32'd1);
  endtask

  task automatic wait_ars(input int target, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (n_ar >= target) break;
      step();
    end
    check(tag, 32'(n_ar >= target), 32'd1);
  endtask

  initial begin
    // Reset values and in-order stream
    EXEC = 1'b1;
    I_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_arvalid", 32'(ARVALID), 32'd0);
    check("rst_ivalid", 32'(I_VALID), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_memwait", 32'(MEM_WAIT), 32'd0);
    check("arlen", 32'(ARLEN), 32'd0);
    check("arsize", 32'(ARSIZE), 32'd2);
    check("arburst", 32'(ARBURST), 32'd1);
    check("rready", 32'(RREADY), 32'd1);
    RSTN = 1'b1;
    pb = n_pop;
    ab = n_ar;
    #1;
    check("memwait_empty", 32'(MEM_WAIT), 32'd1);
    wait_pops(pb + 5, "seq_done");
    for (int i = 0; i < 5; i++) begin
      check("seq_pc", pop_pc[pb+i], 32'(4 * i));
      check("seq_inst", pop_inst[pb+i], mem_word(28'(4 * i)));
    end
    check("seq_first_ar", 32'(ar_log[ab]), 32'h0);
    check("seq_err", 32'(ERR), 32'd0);

    // Back-pressure fills the FIFO and stops issue
    I_READY = 1'b0;
    do_reset();
    repeat (30) step();
    check("full_ar_count", 32'(n_ar - ab), 32'd4);
    check("full_arvalid", 32'(ARVALID), 32'd0);
    check("full_cnt", 32'(dut.cnt), 32'd4);
    check("full_ivalid", 32'(I_VALID), 32'd1);
    check("full_head_pc", I_PC, 32'h0);
    check("full_head_inst", I_INST, 32'h3E80_0093);
    check("full_memwait", 32'(MEM_WAIT), 32'd0);
    I_READY = 1'b1;
    wait_pops(pb + 5, "drain_done");
    for (int i = 0; i < 5; i++) check("drain_pc", pop_pc[pb+i], 32'(4 * i));
    check("resume_ar", 32'(ar_log[ab+4]), 32'h10);

    // Error response on the second beat is sticky
    err_beat = 1;
    do_reset();
    wait_pops(pb + 3, "err_pops");
    check("err_set", 32'(ERR), 32'd1);
    repeat (10) step();
    check("err_sticky", 32'(ERR), 32'd1);
    err_beat = 32'hFFFF_FFFF;

    // Asynchronous reset in the middle of traffic
    I_READY = 1'b0;
    ar_delay = 2;
    repeat (9) step();
    check("pre_rst_err", 32'(ERR), 32'd1);
    @(negedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    check("async_arvalid", 32'(ARVALID), 32'd0);
    check("async_ivalid", 32'(I_VALID), 32'd0);
    check("async_err", 32'(ERR), 32'd0);
    check("async_memwait", 32'(MEM_WAIT), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    ar_delay = 0;
    I_READY = 1'b1;
    pb = n_pop;
    ab = n_ar;
    wait_pops(pb + 1, "restart_pop");
    check("restart_ar", 32'(ar_log[ab]), 32'h0);
    check("restart_pc", pop_pc[pb], 32'h0);

    // Redirect with three reads in flight
    r_en = 1'b0;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      if (n_ar - ab >= 3) break;
      step();
    end
    check("three_inflight", 32'(n_ar - ab), 32'd3);
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h200;
    step();
    REDIRECT = 1'b0;
    r_en = 1'b1;
    @(negedge CLK);
    check("disc3", 32'(dut.disc), 32'd3);
    check("redir_ivalid", 32'(I_VALID), 32'd0);
    wait_pops(pb + 2, "redir_pops");
    check("redir_pc0", pop_pc[pb], 32'h200);
    check("redir_inst0", pop_inst[pb], 32'hA500_0200);
    check("redir_pc1", pop_pc[pb+1], 32'h204);

    // Redirect while an AR is held waiting for ARREADY
    ar_delay = 3;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ARVALID) break;
    end
    check("pend_arvalid", 32'(ARVALID), 32'd1);
    step();
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h103;
    step();
    REDIRECT = 1'b0;
    @(negedge CLK);
    check("hold_valid_a", 32'(ARVALID), 32'd1);
    check("hold_addr_a", 32'(ARADDR), 32'h0);
    check("disc1", 32'(dut.disc), 32'd1);
    step();
    @(negedge CLK);
    check("hold_valid_b", 32'(ARVALID), 32'd1);
    check("hold_addr_b", 32'(ARADDR), 32'h0);
    wait_pops(pb + 1, "pend_pop");
    check("pend_pc", pop_pc[pb], 32'h100);
    check("pend_inst", pop_inst[pb], 32'hA500_0100);
    check("stale_ar", 32'(ar_log[ab]), 32'h0);
    check("new_ar", 32'(ar_log[ab+1]), 32'h100);

    // Address wrap at the top of the offset window
    ar_delay = 0;
    do_reset();
    repeat (4) step();
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h0FFF_FFFC;
    step();
    REDIRECT = 1'b0;
    ab = n_ar;
    pb = n_pop;
    wait_ars(ab + 3, "wrap_ars");
    check("wrap_ar0", 32'(ar_log[ab]), 32'h0FFF_FFFC);
    check("wrap_ar1", 32'(ar_log[ab+1]), 32'h0);
    check("wrap_ar2", 32'(ar_log[ab+2]), 32'h4);
    wait_pops(pb + 2, "wrap_pops");
    check("wrap_pc0", pop_pc[pb], 32'h0FFF_FFFC);
    check("wrap_inst0", pop_inst[pb], 32'hAAFF_FFFC);
    check("wrap_pc1", pop_pc[pb+1], 32'h0);
    check("wrap_inst1", pop_inst[pb+1], 32'h3E80_0093);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
